// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare result encodings, compare modes and
// canonical quiet-NaN construction for any exponent/mantissa split.
package fpu_pkg;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;
    localparam logic [2:0] CMP_UN = 3'b000;

    localparam logic MODE_IEEE  = 1'b0;
    localparam logic MODE_TOTAL = 1'b1;

    // Returned value is zero-extended to 64 bits; callers slice their width.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier for an IEEE-754-style format.
module fp_classify #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic                 is_zero,
    output logic                 is_nan,
    output logic                 is_inf
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    // Split fields and derive class flags.
    always_comb begin
        exp_s   = op[EXP_W+MAN_W-1:MAN_W];
        man_s   = op[MAN_W-1:0];
        sign    = op[EXP_W+MAN_W];
        is_zero = (exp_s == {EXP_W{1'b0}}) && (man_s == {MAN_W{1'b0}});
        is_nan  = (&exp_s) && (|man_s);
        is_inf  = (&exp_s) && !(|man_s);
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready floating-point comparator with IEEE and totalOrder
// modes plus min/max results.
module fp_compare_pipe
    import fpu_pkg::*;
#(
    parameter int  EXP_W = 5,
    parameter int  MAN_W = 10,
    parameter int  TAG_W = 4,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_cmp,
    output logic             out_unord,
    output logic [W-1:0]     out_min,
    output logic [W-1:0]     out_max,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [63:0]  QNAN_FULL = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN      = QNAN_FULL[W-1:0];
    localparam logic [W-1:0] MSB_MASK  = {1'b1, {(W-1){1'b0}}};

    logic             s1_adv_s, s2_adv_s;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [W-1:0]     x1_q, x1_d, y1_q, y1_d;
    logic             mode1_q, mode1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic [2:0]       cmp_q, cmp_d, cmp_s;
    logic             unord_q, unord_d, unord_s;
    logic [W-1:0]     min_q, min_d, max_q, max_d, min_s, max_s;
    logic             sx_s, sy_s, zx_s, zy_s, nx_s, ny_s, ix_s, iy_s;
    logic             mag_gt_s, mag_eq_s;
    logic [W-1:0]     key_x_s, key_y_s;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
        .op(x1_q), .sign(sx_s), .is_zero(zx_s), .is_nan(nx_s), .is_inf(ix_s)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
        .op(y1_q), .sign(sy_s), .is_zero(zy_s), .is_nan(ny_s), .is_inf(iy_s)
    );

    // Handshake: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv_s = !v2_q || out_ready;
        s1_adv_s = !v1_q || s2_adv_s;
        in_ready = s1_adv_s;
    end

    // Stage 1 capture of operands, mode and tag.
    always_comb begin
        v1_d    = v1_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        mode1_d = mode1_q;
        tag1_d  = tag1_q;
        if (s1_adv_s) begin
            v1_d = in_valid;
            if (in_valid) begin
                x1_d    = in_x;
                y1_d    = in_y;
                mode1_d = in_mode;
                tag1_d  = in_tag;
            end else begin
                x1_d = x1_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // Resolve ordering from stage-1 operands.
    always_comb begin
        mag_gt_s = x1_q[W-2:0] > y1_q[W-2:0];
        mag_eq_s = x1_q[W-2:0] == y1_q[W-2:0];
        key_x_s  = sx_s ? ~x1_q : (x1_q ^ MSB_MASK);
        key_y_s  = sy_s ? ~y1_q : (y1_q ^ MSB_MASK);
        cmp_s    = CMP_UN;
        unord_s  = 1'b0;
        if (mode1_q == MODE_IEEE) begin
            if (nx_s || ny_s) begin
                cmp_s   = CMP_UN;
                unord_s = 1'b1;
            end else if (zx_s && zy_s) begin
                cmp_s = CMP_EQ;
            end else if (sx_s != sy_s) begin
                cmp_s = sx_s ? CMP_LT : CMP_GT;
            end else if (mag_eq_s || (ix_s && iy_s)) begin
                cmp_s = CMP_EQ;
            end else if (mag_gt_s) begin
                cmp_s = sx_s ? CMP_LT : CMP_GT;
            end else begin
                cmp_s = sx_s ? CMP_GT : CMP_LT;
            end
        end else begin
            // Sign-folded keys make the bit patterns order as unsigned ints.
            if (key_x_s > key_y_s) begin
                cmp_s = CMP_GT;
            end else if (key_x_s == key_y_s) begin
                cmp_s = CMP_EQ;
            end else begin
                cmp_s = CMP_LT;
            end
        end
    end

    // Select min/max from the resolved ordering.
    always_comb begin
        min_s = x1_q;
        max_s = x1_q;
        case (cmp_s)
            CMP_LT: begin
                min_s = x1_q;
                max_s = y1_q;
            end
            CMP_GT: begin
                min_s = y1_q;
                max_s = x1_q;
            end
            CMP_EQ: begin
                min_s = x1_q;
                max_s = x1_q;
            end
            default: begin
                if (nx_s && ny_s) begin
                    min_s = QNAN;
                    max_s = QNAN;
                end else if (nx_s) begin
                    min_s = y1_q;
                    max_s = y1_q;
                end else begin
                    min_s = x1_q;
                    max_s = x1_q;
                end
            end
        endcase
    end

    // Stage 2 result holding register.
    always_comb begin
        v2_d    = v2_q;
        cmp_d   = cmp_q;
        unord_d = unord_q;
        min_d   = min_q;
        max_d   = max_q;
        tag2_d  = tag2_q;
        if (s2_adv_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                cmp_d   = cmp_s;
                unord_d = unord_s;
                min_d   = min_s;
                max_d   = max_s;
                tag2_d  = tag1_q;
            end else begin
                cmp_d = cmp_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            x1_q    <= {W{1'b0}};
            y1_q    <= {W{1'b0}};
            mode1_q <= 1'b0;
            tag1_q  <= {TAG_W{1'b0}};
            v2_q    <= 1'b0;
            cmp_q   <= CMP_UN;
            unord_q <= 1'b0;
            min_q   <= {W{1'b0}};
            max_q   <= {W{1'b0}};
            tag2_q  <= {TAG_W{1'b0}};
        end else begin
            v1_q    <= v1_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            mode1_q <= mode1_d;
            tag1_q  <= tag1_d;
            v2_q    <= v2_d;
            cmp_q   <= cmp_d;
            unord_q <= unord_d;
            min_q   <= min_d;
            max_q   <= max_d;
            tag2_q  <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_cmp   = cmp_q;
    assign out_unord = unord_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe at half precision.
module tb_fp_compare_pipe;
    import fpu_pkg::*;

    typedef struct packed {
        logic [2:0]  cmp;
        logic        unord;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [3:0]  tag;
        logic [31:0] acc;
        logic        chk_lat;
    } exp_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        mode;
        logic [2:0]  cmp;
        logic        unord;
        logic [15:0] mn;
        logic [15:0] mx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = 16'h0000;
    logic [15:0] in_y = 16'h0000;
    logic        in_mode = 1'b0;
    logic [3:0]  in_tag = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_cmp;
    logic        out_unord;
    logic [15:0] out_min;
    logic [15:0] out_max;
    logic [3:0]  out_tag;

    exp_t q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic bp_en = 1'b0;
    int   bp_k = 0;

    fp_compare_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmp(out_cmp),
        .out_unord(out_unord), .out_min(out_min), .out_max(out_max),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: non-NaN IEEE ordering equals key ordering except +/-0.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic m, input logic [3:0] tag);
        exp_t e;
        logic nx, ny, zx, zy;
        logic [15:0] kx, ky;
        nx = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
        ny = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
        zx = (x[14:0] == 15'd0);
        zy = (y[14:0] == 15'd0);
        kx = x[15] ? ~x : (x | 16'h8000);
        ky = y[15] ? ~y : (y | 16'h8000);
        e = '0;
        e.tag = tag;
        if (!m && (nx || ny)) begin
            e.cmp = 3'b000; e.unord = 1'b1;
            e.mn = (nx && ny) ? 16'h7E00 : (nx ? y : x);
            e.mx = e.mn;
        end else begin
            if (!m && zx && zy) e.cmp = 3'b001;
            else if (kx < ky)   e.cmp = 3'b100;
            else if (kx > ky)   e.cmp = 3'b010;
            else                e.cmp = 3'b001;
            e.mn = (e.cmp == 3'b010) ? y : x;
            e.mx = (e.cmp == 3'b100) ? y : x;
        end
        return e;
    endfunction

    function automatic exp_t from_vec(input vec_t v, input logic [3:0] tag, input logic lat);
        exp_t e;
        e = '0;
        e.cmp = v.cmp; e.unord = v.unord; e.mn = v.mn; e.mx = v.mx;
        e.tag = tag; e.chk_lat = lat;
        return e;
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic m,
                        input logic [3:0] tag, input exp_t e_in, input logic must_ready);
        exp_t e;
        logic ok;
        int tries;
        e = e_in; ok = 1'b0; tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = x; in_y = y; in_mode = m; in_tag = tag;
            #1;
            ok = in_ready;
            e.acc = cyc;
            if (must_ready) begin
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL in_ready_stream: got %b want 1 (tag %0h)", ok, tag);
                end
            end
            @(posedge clk);
            if (ok) q.push_back(e);
            tries++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: tag %0h not accepted in 50 cycles", tag);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
    endtask

    // Backpressure pattern generator: out_ready = 1,0,0,1,0,0,...
    initial forever begin
        @(negedge clk);
        if (bp_en) begin
            out_ready = (bp_k % 3 == 0);
            bp_k++;
        end
    end

    // Monitor: handshake rule, output hold stability, scoreboard compare.
    initial begin
        logic        stalled;
        logic [2:0]  s_cmp;
        logic        s_unord;
        logic [15:0] s_mn, s_mx;
        logic [3:0]  s_tag;
        logic        exp_ir;
        exp_t e;
        stalled = 1'b0;
        s_cmp = 3'b000; s_unord = 1'b0; s_mn = 16'h0; s_mx = 16'h0; s_tag = 4'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                exp_ir = !(q.size() == 2 && !out_ready);
                checks++;
                if (in_ready !== exp_ir) begin
                    errors++;
                    $display("FAIL in_ready: got %b want %b (inflight %0d out_ready %b)",
                             in_ready, exp_ir, q.size(), out_ready);
                end
                if (stalled) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_cmp !== s_cmp || out_unord !== s_unord ||
                        out_min !== s_mn || out_max !== s_mx || out_tag !== s_tag) begin
                        errors++;
                        $display("FAIL hold: got v=%b cmp=%b un=%b min=%h max=%h tag=%h want v=1 cmp=%b un=%b min=%h max=%h tag=%h",
                                 out_valid, out_cmp, out_unord, out_min, out_max, out_tag,
                                 s_cmp, s_unord, s_mn, s_mx, s_tag);
                    end
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected: got result tag=%h cmp=%b want no result",
                                 out_tag, out_cmp);
                    end else if (out_ready) begin
                        e = q.pop_front();
                        checks++;
                        if (out_cmp !== e.cmp || out_unord !== e.unord || out_min !== e.mn ||
                            out_max !== e.mx || out_tag !== e.tag) begin
                            errors++;
                            $display("FAIL result: got cmp=%b un=%b min=%h max=%h tag=%h want cmp=%b un=%b min=%h max=%h tag=%h",
                                     out_cmp, out_unord, out_min, out_max, out_tag,
                                     e.cmp, e.unord, e.mn, e.mx, e.tag);
                        end
                        if (e.chk_lat) begin
                            checks++;
                            if (cyc - e.acc != 32'd2) begin
                                errors++;
                                $display("FAIL latency: got %0d want 2 (tag %h)", cyc - e.acc, e.tag);
                            end
                        end
                    end else begin
                        checks = checks;
                    end
                    stalled = !out_ready;
                    s_cmp = out_cmp; s_unord = out_unord; s_mn = out_min;
                    s_mx = out_max; s_tag = out_tag;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 3'b100, 1'b0, 16'h3C00, 16'h4000};
        vecs[1]  = '{16'h4000, 16'h3C00, 1'b0, 3'b010, 1'b0, 16'h3C00, 16'h4000};
        vecs[2]  = '{16'hBC00, 16'hC000, 1'b0, 3'b010, 1'b0, 16'hC000, 16'hBC00};
        vecs[3]  = '{16'h8000, 16'h0000, 1'b0, 3'b001, 1'b0, 16'h8000, 16'h8000};
        vecs[4]  = '{16'h8000, 16'h0000, 1'b1, 3'b100, 1'b0, 16'h8000, 16'h0000};
        vecs[5]  = '{16'h7E00, 16'h3C00, 1'b0, 3'b000, 1'b1, 16'h3C00, 16'h3C00};
        vecs[6]  = '{16'hFE01, 16'h7E00, 1'b0, 3'b000, 1'b1, 16'h7E00, 16'h7E00};
        vecs[7]  = '{16'hFE00, 16'hFC00, 1'b1, 3'b100, 1'b0, 16'hFE00, 16'hFC00};
        vecs[8]  = '{16'h7C00, 16'h7C00, 1'b0, 3'b001, 1'b0, 16'h7C00, 16'h7C00};
        vecs[9]  = '{16'hFE01, 16'h7E00, 1'b1, 3'b100, 1'b0, 16'hFE01, 16'h7E00};
        vecs[10] = '{16'h3C00, 16'h3C00, 1'b1, 3'b001, 1'b0, 16'h3C00, 16'h3C00};
        vecs[11] = '{16'h0001, 16'h8001, 1'b0, 3'b010, 1'b0, 16'h8001, 16'h0001};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_cmp !== 3'b000 || out_unord !== 1'b0 ||
            out_min !== 16'h0 || out_max !== 16'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b cmp=%b un=%b min=%h max=%h tag=%h want all zero",
                     out_valid, out_cmp, out_unord, out_min, out_max, out_tag);
        end

        // Directed vectors streamed back-to-back with latency checks.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].mode, 4'(i), from_vec(vecs[i], 4'(i), 1'b1), 1'b1);
        end
        idle();
        drain();

        // Backpressure with out_ready cycling 1,0,0.
        bp_k = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].mode, 4'(i), from_vec(vecs[i], 4'(i), 1'b0), 1'b0);
        end
        idle();
        drain();
        bp_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Throughput: random operands, every cycle accepted, latency 2.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] rx, ry;
            logic        rm;
            exp_t        e;
            rx = 16'($urandom);
            ry = (i % 4 == 0) ? rx : 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            e = model(rx, ry, rm, 4'(i));
            e.chk_lat = 1'b1;
            send(rx, ry, rm, 4'(i), e, 1'b1);
        end
        idle();
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(vecs[0].x, vecs[0].y, vecs[0].mode, 4'h1, from_vec(vecs[0], 4'h1, 1'b0), 1'b0);
        send(vecs[1].x, vecs[1].y, vecs[1].mode, 4'h2, from_vec(vecs[1], 4'h2, 1'b0), 1'b0);
        idle();
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        checks++;
        if (out_valid !== 1'b0 || out_cmp !== 3'b000 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b cmp=%b tag=%h want 0 000 0",
                     out_valid, out_cmp, out_tag);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        send(vecs[3].x, vecs[3].y, vecs[3].mode, 4'h9, from_vec(vecs[3], 4'h9, 1'b1), 1'b1);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
